sat_accum: RTL and testbench

- Sequential accumulator directly downstream of the 12-bit saturating adder stage.
- Accepts a burst of 12-bit samples over a valid/ready stream and folds them into one running sum, using the same three add modes as the adder (wrap, signed saturate, unsigned saturate).
- Presents the final sum, plus a sticky saturation flag, on a valid/ready output port.
- Sits between the sample source and the result consumer in the lab datapath.

---
 rtl/sat_accum.sv | 173 +++++++++++++++++
 tb/tb_sat_accum.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_accum.sv
// -----------------------------------------------------------------------------
// sat_accum
//
// Folds a burst of len+1 twelve-bit samples into one running sum and presents
// the result, with a sticky "some add clamped" flag, on a valid/ready port.
// Three add modes, shared with the upstream saturating adder:
//   mode 1x : wrap (modulo 2^12), never flags saturation
//   mode 01 : two's-complement saturate to 0x7FF / 0x800
//   mode 00 : unsigned saturate to 0xFFF (no clamp at zero)
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   sample handshake, in_data carries the sample
//   mode, len             add mode and burst length minus one; both are
//                         sampled only with the first sample of a burst
//   out_valid / out_ready result handshake
//   out_data, out_sat     accumulated sum and sticky saturation flag
//
// State table:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for the first sample of a burst
//   ST_ACCUM | folding further samples into acc until the burst completes
//   ST_HOLD  | result presented on the output port, inputs not accepted
//
// Every output comes straight from a flop, so nothing on the input side
// reaches an output in the same cycle.
// -----------------------------------------------------------------------------
module sat_accum #(
    parameter int W     = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [1:0]       mode_l_q, mode_l_d;
    logic [LEN_W-1:0] len_l_q, len_l_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [W:0]       sum;
    logic [LEN_W-1:0] cnt_inc;

    // Returns {clamp_applied, result}.
    function automatic logic [W:0] add_f(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   m
    );
        logic [W:0] r;
        logic       ovf;
        logic [W:0] res;
        r   = {1'b0, a} + {1'b0, b};
        ovf = 1'b0;
        res = {1'b0, r[W-1:0]};
        if (m[1]) begin
            res = {1'b0, r[W-1:0]};
        end else if (m[0]) begin
            // Signed overflow: operands agree in sign, result disagrees.
            ovf = (~a[W-1] & ~b[W-1] & r[W-1]) | (a[W-1] & b[W-1] & ~r[W-1]);
            if (ovf) begin
                res = a[W-1] ? {1'b1, 1'b1, {(W-1){1'b0}}}
                             : {1'b1, 1'b0, {(W-1){1'b1}}};
            end
        end else begin
            if (r[W]) begin
                res = {1'b1, {W{1'b1}}};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        mode_l_d = mode_l_q;
        len_l_d  = len_l_q;

        // in_ready_q is low in HOLD and during the first cycle after reset,
        // so it alone gates acceptance.
        accept  = in_valid & in_ready_q;
        sum     = add_f(acc_q, in_data, mode_l_q);
        cnt_inc = cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d    = in_data;
                    sat_d    = 1'b0;
                    cnt_d    = '0;
                    mode_l_d = mode;
                    len_l_d  = len;
                    state_d  = (len == '0) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = sum[W-1:0];
                    sat_d = sat_q | sum[W];
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_l_q) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered from the next state, so in_ready
        // drops on the same edge that enters HOLD and returns on the edge
        // that leaves it.
        in_ready_d  = (state_d != ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            mode_l_q    <= 2'b00;
            len_l_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            mode_l_q    <= mode_l_d;
            len_l_q     <= len_l_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_sat_accum.sv
// -----------------------------------------------------------------------------
// tb_sat_accum
//
// Bench for sat_accum. Directed bursts come from a table of records holding
// the burst and its expected result; random bursts get their expectation from
// an integer-arithmetic model. Expected results are queued when a burst is
// driven and compared when the result handshake happens. Backpressure and
// reset-mid-burst are separate hand-written sequences.
// -----------------------------------------------------------------------------
module tb_sat_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic [1:0]  mode;
    logic [3:0]  len;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_sat;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]        mode;
        logic [3:0]        len;
        logic [15:0][11:0] s;
        logic [11:0]       exp_data;
        logic              exp_sat;
    } vec_t;

    typedef struct {
        logic [11:0] d;
        logic        s;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[9];

    sat_accum #(.W(12), .LEN_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_add(input int a, input int b, input logic [1:0] m,
                                      output int r, output bit c);
        int sa, sb, s;
        c = 1'b0;
        if (m[1]) begin
            r = (a + b) % 4096;
        end else if (m == 2'b01) begin
            sa = (a >= 2048) ? a - 4096 : a;
            sb = (b >= 2048) ? b - 4096 : b;
            s  = sa + sb;
            if (s > 2047) begin
                r = 2047; c = 1'b1;
            end else if (s < -2048) begin
                r = 2048; c = 1'b1;
            end else begin
                r = (s < 0) ? s + 4096 : s;
            end
        end else begin
            s = a + b;
            if (s > 4095) begin
                r = 4095; c = 1'b1;
            end else begin
                r = s;
            end
        end
    endfunction

    // Result monitor: out_ready only changes just after a rising edge, so a
    // valid&ready seen on the falling edge is a transfer on the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'(1'b0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_sat", 32'(out_sat), 32'(e.s));
            end
        end
    end

    // Offer one sample after 'gap' idle cycles; returns 1 ns after the edge
    // that accepted it.
    task automatic send(input logic [11:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("in_ready_timeout", 32'(in_ready), 32'(1'b1));
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    // mode/len are scrambled after the first sample; the DUT must ignore that.
    task automatic send_burst(input logic [1:0] m, input logic [3:0] l,
                              input logic [15:0][11:0] s, input int gmax);
        mode = m;
        len  = l;
        for (int i = 0; i <= int'(l); i++) begin
            send(s[i], (i == 0) ? 0 : int'($urandom_range(gmax)));
            if (i == 0) begin
                mode = 2'($urandom_range(3));
                len  = 4'($urandom_range(15));
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0][11:0] rs;
        logic [1:0]        rm;
        logic [3:0]        rl;
        int                acc;
        bit                sat, c;

        // Directed table
        for (int i = 0; i < 9; i++) tbl[i].s = '0;
        tbl[0].mode = 2'b00; tbl[0].len = 4'd2;
        tbl[0].s[0] = 12'h800; tbl[0].s[1] = 12'h700; tbl[0].s[2] = 12'h100;
        tbl[0].exp_data = 12'hFFF; tbl[0].exp_sat = 1'b1;
        tbl[1].mode = 2'b01; tbl[1].len = 4'd1;
        tbl[1].s[0] = 12'h7F0; tbl[1].s[1] = 12'h020;
        tbl[1].exp_data = 12'h7FF; tbl[1].exp_sat = 1'b1;
        tbl[2].mode = 2'b01; tbl[2].len = 4'd1;
        tbl[2].s[0] = 12'h800; tbl[2].s[1] = 12'hFFF;
        tbl[2].exp_data = 12'h800; tbl[2].exp_sat = 1'b1;
        tbl[3].mode = 2'b10; tbl[3].len = 4'd1;
        tbl[3].s[0] = 12'hFFF; tbl[3].s[1] = 12'h002;
        tbl[3].exp_data = 12'h001; tbl[3].exp_sat = 1'b0;
        tbl[4].mode = 2'b11; tbl[4].len = 4'd1;
        tbl[4].s[0] = 12'hFFF; tbl[4].s[1] = 12'h002;
        tbl[4].exp_data = 12'h001; tbl[4].exp_sat = 1'b0;
        tbl[5].mode = 2'b01; tbl[5].len = 4'd2;
        tbl[5].s[0] = 12'h7FF; tbl[5].s[1] = 12'h001; tbl[5].s[2] = 12'hFFE;
        tbl[5].exp_data = 12'h7FD; tbl[5].exp_sat = 1'b1;
        // 16 x 0x100: reaches 0xF00 after 15, clamps on the 16th
        tbl[6].mode = 2'b00; tbl[6].len = 4'd15;
        for (int i = 0; i < 16; i++) tbl[6].s[i] = 12'h100;
        tbl[6].exp_data = 12'hFFF; tbl[6].exp_sat = 1'b1;
        // 16 x 0x101 = 0x1010 wraps to 0x010
        tbl[7].mode = 2'b10; tbl[7].len = 4'd15;
        for (int i = 0; i < 16; i++) tbl[7].s[i] = 12'h101;
        tbl[7].exp_data = 12'h010; tbl[7].exp_sat = 1'b0;
        // Signed: 0x7FF (clamped), 0x6FF, 0x700; wrap would end at 0x701
        tbl[8].mode = 2'b01; tbl[8].len = 4'd3;
        tbl[8].s[0] = 12'h700; tbl[8].s[1] = 12'h100;
        tbl[8].s[2] = 12'hF00; tbl[8].s[3] = 12'h001;
        tbl[8].exp_data = 12'h700; tbl[8].exp_sat = 1'b1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 2'b00;
        len       = '0;
        out_ready = 1'b1;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            exp_q.push_back('{d: tbl[i].exp_data, s: tbl[i].exp_sat});
            send_burst(tbl[i].mode, tbl[i].len, tbl[i].s, (i % 3));
            @(negedge clk);
            chk($sformatf("latency_vec%0d", i), 32'(out_valid), 32'd1);
            drain();
        end

        // Backpressure: result held, pending sample not consumed during HOLD
        out_ready = 1'b0;
        exp_q.push_back('{d: 12'h123, s: 1'b0});
        mode = 2'b00;
        len  = 4'd0;
        send(12'h123, 0);
        in_valid = 1'b1;
        in_data  = 12'h456;
        mode     = 2'b10;
        len      = 4'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h123);
            mode = 2'(k);
        end
        @(posedge clk);
        #1;
        mode = 2'b00;
        len  = 4'd0;
        exp_q.push_back('{d: 12'h456, s: 1'b0});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a burst
        mode = 2'b00;
        len  = 4'd3;
        send(12'h010, 0);
        send(12'h020, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_sat", 32'(out_sat), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_output", 32'(out_valid), 32'd0);
        end
        exp_q.push_back('{d: 12'h005, s: 1'b0});
        len = 4'd0;
        send(12'h005, 0);
        drain();

        // Random bursts with gaps, expectations from the integer model
        for (int k = 0; k < 12; k++) begin
            rm = 2'($urandom_range(3));
            rl = 4'($urandom_range(15));
            for (int i = 0; i < 16; i++) rs[i] = 12'($urandom_range(4095));
            acc = int'(rs[0]);
            sat = 1'b0;
            for (int i = 1; i <= int'(rl); i++) begin
                model_add(acc, int'(rs[i]), rm, acc, c);
                sat = sat | c;
            end
            exp_q.push_back('{d: 12'(acc), s: sat});
            send_burst(rm, rl, rs, 3);
            drain();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
